// File: rtl/keccak_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
//   Shared types, constants and helpers for the Keccak-f[1600] datapath.
//   - lane_t / state_t : a 64-bit lane and the 25-lane state. state_t is a
//     packed 25x64 array, so lane i occupies bits [64*i +: 64] of the
//     flattened 1600-bit vector. Lane (x,y) is at index lane_idx(x,y) = x+5*y.
//   - RHO               : left-rotate offsets for the rho step, indexed by
//     lane_idx(x,y).
//   - core_state_e      : control states of the iterative core.
// -----------------------------------------------------------------------------
package keccak_pkg;

  localparam int LANE_W     = 64;
  localparam int NUM_LANES  = 25;
  localparam int MAX_ROUNDS = 24;
  localparam int STATE_W    = LANE_W * NUM_LANES;

  typedef logic [LANE_W-1:0]        lane_t;
  typedef lane_t [NUM_LANES-1:0]    state_t;

  // Rho rotation offsets, row-major in y: entry x+5*y belongs to lane (x,y).
  localparam int unsigned RHO [NUM_LANES] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } core_state_e;

  function automatic int lane_idx(input int x, input int y);
    return x + 5 * y;
  endfunction

  // Left rotate; a zero offset falls out naturally because a >> 64 is zero.
  function automatic lane_t rotl(input lane_t a, input int unsigned n);
    return (a << n) | (a >> (LANE_W - n));
  endfunction

endpackage

// File: rtl/keccak_f1600_iter_core_if.sv
// -----------------------------------------------------------------------------
// keccak_f1600_iter_core_if
//   Bundle between the absorb/squeeze controller (plus its round-constant
//   lookup) and the iterative permutation core.
//   master : controller side - drives start_i, state_i, round_constant_i.
//   slave  : the core        - drives ready_o, round_number_o, state_o, valid_o.
//   Signal suffixes are written from the core's point of view.
// -----------------------------------------------------------------------------
interface keccak_f1600_iter_core_if;
  import keccak_pkg::*;

  logic               start_i;
  logic [STATE_W-1:0] state_i;
  logic               ready_o;
  logic [4:0]         round_number_o;
  lane_t              round_constant_i;
  logic [STATE_W-1:0] state_o;
  logic               valid_o;

  modport master (
    output start_i,
    output state_i,
    output round_constant_i,
    input  ready_o,
    input  round_number_o,
    input  state_o,
    input  valid_o
  );

  modport slave (
    input  start_i,
    input  state_i,
    input  round_constant_i,
    output ready_o,
    output round_number_o,
    output state_o,
    output valid_o
  );

endinterface

// File: rtl/keccak_f1600_iter_core_round_comb.sv
// -----------------------------------------------------------------------------
// keccak_round_comb
//   One full Keccak-f[1600] round, purely combinational:
//   theta -> rho -> pi -> chi -> iota.
//   Ports:
//     state_in  : state before the round (lane (x,y) at index x+5*y)
//     rc_in     : iota round constant, XORed into lane (0,0)
//     state_out : state after the round
// -----------------------------------------------------------------------------
module keccak_round_comb
  import keccak_pkg::*;
(
  input  state_t state_in,
  input  lane_t  rc_in,
  output state_t state_out
);

  lane_t  col_par [5];   // theta column parities C[x]
  lane_t  col_mix [5];   // theta D[x]
  state_t theta_s;
  state_t pi_s;          // rho and pi combined
  state_t chi_s;

  // NOTE: every variable written here is given a value on every pass through
  // the block (loops are fully unrolled and cover all indices), so no latch.
  always_comb begin
    for (int x = 0; x < 5; x++) begin
      col_par[x] = state_in[lane_idx(x, 0)] ^ state_in[lane_idx(x, 1)] ^
                   state_in[lane_idx(x, 2)] ^ state_in[lane_idx(x, 3)] ^
                   state_in[lane_idx(x, 4)];
    end

    for (int x = 0; x < 5; x++) begin
      col_mix[x] = col_par[(x + 4) % 5] ^ rotl(col_par[(x + 1) % 5], 1);
    end

    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        theta_s[lane_idx(x, y)] = state_in[lane_idx(x, y)] ^ col_mix[x];
      end
    end

    // rho rotates lane (x,y) in place; pi then moves it to (y, 2x+3y).
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        pi_s[lane_idx(y, (2 * x + 3 * y) % 5)] =
          rotl(theta_s[lane_idx(x, y)], RHO[lane_idx(x, y)]);
      end
    end

    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        chi_s[lane_idx(x, y)] = pi_s[lane_idx(x, y)] ^
          (~pi_s[lane_idx((x + 1) % 5, y)] & pi_s[lane_idx((x + 2) % 5, y)]);
      end
    end

    state_out    = chi_s;
    state_out[0] = chi_s[0] ^ rc_in;
  end

endmodule

// File: rtl/keccak_f1600_iter_core.sv
// -----------------------------------------------------------------------------
// keccak_f1600_iter_core
//   Iterative Keccak-f[1600]: one round per clock around a 1600-bit state
//   register. Rounds FIRST_ROUND..23 are applied; the round-constant lookup
//   lives in the parent and answers round_number_o combinationally.
//   Ports:
//     clk     : clock, rising edge
//     rst     : synchronous, active-high reset
//     core_if : slave modport of keccak_f1600_iter_core_if
//       start_i / state_i     load a state and start (only while ready_o=1)
//       ready_o               1 in IDLE and DONE
//       round_number_o        round index for the constant lookup
//       round_constant_i      iota constant for round_number_o, same cycle
//       state_o / valid_o     state register; valid_o=1 in DONE
//   Latency start -> valid_o is NUM_ROUNDS+1 clock edges. The result is held
//   in DONE until the next accepted start.
// -----------------------------------------------------------------------------
module keccak_f1600_iter_core
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS  = 24,
  parameter int FIRST_ROUND = MAX_ROUNDS - NUM_ROUNDS
) (
  input  logic                    clk,
  input  logic                    rst,
  keccak_f1600_iter_core_if.slave core_if
);

  localparam logic [4:0] FIRST_RND = 5'(FIRST_ROUND);
  localparam logic [4:0] LAST_RND  = 5'(MAX_ROUNDS - 1);

  core_state_e fsm_q,   fsm_d;
  logic [4:0]  round_q, round_d;
  state_t      state_q, state_d;
  state_t      round_out;

  keccak_round_comb u_round (
    .state_in  (state_q),
    .rc_in     (core_if.round_constant_i),
    .state_out (round_out)
  );

  // NOTE: the 1600-bit state register is reset along with the control state
  // so that state_o reads as zero out of reset and after an aborted run.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      round_q <= FIRST_RND;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;

    unique case (fsm_q)
      ST_IDLE, ST_DONE: begin
        if (core_if.start_i) begin
          state_d = core_if.state_i;
          round_d = FIRST_RND;
          fsm_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        state_d = round_out;
        if (round_q == LAST_RND) begin
          // Re-aim the lookup at the first round while the result is held.
          round_d = FIRST_RND;
          fsm_d   = ST_DONE;
        end else begin
          round_d = round_q + 5'd1;
        end
      end

      default: begin
        fsm_d   = ST_IDLE;
        round_d = FIRST_RND;
      end
    endcase
  end

  assign core_if.ready_o        = (fsm_q != ST_RUN);
  assign core_if.valid_o        = (fsm_q == ST_DONE);
  assign core_if.round_number_o = round_q;
  assign core_if.state_o        = state_q;

endmodule

// File: tb/tb_keccak_f1600_iter_core.sv
// -----------------------------------------------------------------------------
// tb_keccak_f1600_iter_core
//   Two cores (24 and 12 rounds) share clk/rst. A reference Keccak-f model,
//   with round constants from the rc() LFSR and rho offsets from the
//   triangular-number walk, predicts every result; expected states are queued
//   when a start is driven and popped when valid_o is seen.
// -----------------------------------------------------------------------------
module tb_keccak_f1600_iter_core;
  import keccak_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keccak_f1600_iter_core_if if24 ();
  keccak_f1600_iter_core_if if12 ();

  keccak_f1600_iter_core #(.NUM_ROUNDS(24)) dut24 (.clk(clk), .rst(rst), .core_if(if24));
  keccak_f1600_iter_core #(.NUM_ROUNDS(12)) dut12 (.clk(clk), .rst(rst), .core_if(if12));

  // ---------------- reference model ----------------
  int rho_off [5][5];

  function automatic logic rc_bit(input int t);
    logic [7:0] r;
    logic       fb;
    r = 8'h01;
    for (int i = 0; i < t % 255; i++) begin
      fb = r[7];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h71;
    end
    return r[0];
  endfunction

  function automatic logic [63:0] rc_of(input int rnd);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < 7; j++) v[(1 << j) - 1] = rc_bit(j + 7 * rnd);
    return v;
  endfunction

  function automatic logic [63:0] rol(input logic [63:0] a, input int n);
    int m;
    m = n % 64;
    if (m == 0) return a;
    return (a << m) | (a >> (64 - m));
  endfunction

  task automatic init_rho();
    int x, y, nx;
    rho_off[0][0] = 0;
    x = 1; y = 0;
    for (int t = 0; t < 24; t++) begin
      rho_off[x][y] = ((t + 1) * (t + 2) / 2) % 64;
      nx = y;
      y  = (2 * x + 3 * y) % 5;
      x  = nx;
    end
  endtask

  function automatic logic [1599:0] keccak_ref(input logic [1599:0] s, input int nr);
    logic [63:0] a [5][5];
    logic [63:0] b [5][5];
    logic [63:0] c [5];
    logic [63:0] d;
    logic [1599:0] res;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) a[x][y] = s[64 * (x + 5 * y) +: 64];
    for (int r = 24 - nr; r < 24; r++) begin
      for (int x = 0; x < 5; x++) c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
      for (int x = 0; x < 5; x++) begin
        d = c[(x + 4) % 5] ^ rol(c[(x + 1) % 5], 1);
        for (int y = 0; y < 5; y++) a[x][y] = a[x][y] ^ d;
      end
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++) b[y][(2 * x + 3 * y) % 5] = rol(a[x][y], rho_off[x][y]);
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          a[x][y] = b[x][y] ^ (~b[(x + 1) % 5][y] & b[(x + 2) % 5][y]);
      a[0][0] = a[0][0] ^ rc_of(r);
    end
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) res[64 * (x + 5 * y) +: 64] = a[x][y];
    return res;
  endfunction

  // ---------------- bench plumbing ----------------
  logic          start_v [2];
  logic [1599:0] st_v    [2];
  logic          ready_w [2];
  logic          valid_w [2];
  logic [4:0]    rn_w    [2];
  logic [1599:0] sout_w  [2];

  assign if24.start_i          = start_v[0];
  assign if24.state_i          = st_v[0];
  assign if24.round_constant_i = rc_of(int'(if24.round_number_o));
  assign if12.start_i          = start_v[1];
  assign if12.state_i          = st_v[1];
  assign if12.round_constant_i = rc_of(int'(if12.round_number_o));

  assign ready_w[0] = if24.ready_o;        assign ready_w[1] = if12.ready_o;
  assign valid_w[0] = if24.valid_o;        assign valid_w[1] = if12.valid_o;
  assign rn_w[0]    = if24.round_number_o; assign rn_w[1]    = if12.round_number_o;
  assign sout_w[0]  = if24.state_o;        assign sout_w[1]  = if12.state_o;

  int total = 0;
  int bad   = 0;
  logic [1599:0] exp_q [$];
  logic [1599:0] last_exp;

  function automatic int nr_of(input int d);
    return (d == 0) ? 24 : 12;
  endfunction

  function automatic logic [4:0] first_of(input int d);
    return (d == 0) ? 5'd0 : 5'd12;
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int i = 0; i < 50; i++) s[32 * i +: 32] = $urandom();
    return s;
  endfunction

  function automatic int first_diff(input logic [1599:0] a, input logic [1599:0] b);
    for (int i = 0; i < 25; i++) if (a[64 * i +: 64] !== b[64 * i +: 64]) return i;
    return 0;
  endfunction

  task automatic report_state(input string name, input int d,
                              input logic [1599:0] got, input logic [1599:0] want);
    int l;
    l = first_diff(got, want);
    bad++;
    $display("FAIL %s dut%0d: lane %0d got %h want %h", name, d, l,
             got[64 * l +: 64], want[64 * l +: 64]);
  endtask

  // Drive start for one edge (core must be ready); queue the prediction.
  task automatic do_start(input int d, input logic [1599:0] s);
    start_v[d] = 1'b1;
    st_v[d]    = s;
    exp_q.push_back(keccak_ref(s, nr_of(d)));
    @(negedge clk);
    start_v[d] = 1'b0;
    st_v[d]    = rand_state();
  endtask

  // Wait (bounded) for valid_o and compare against the oldest prediction.
  task automatic wait_result(input int d, input string name);
    int n;
    logic [1599:0] e;
    n = 0;
    while (valid_w[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    last_exp = e;
    total++;
    if (valid_w[d] !== 1'b1) begin
      bad++;
      $display("FAIL %s dut%0d: valid_o timeout got %b want 1", name, d, valid_w[d]);
    end else if (sout_w[d] !== e) begin
      report_state(name, d, sout_w[d], e);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b1;
      st_v[d]    = rand_state();
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (ready_w[d] !== 1'b1) begin
        bad++; $display("FAIL reset_ready dut%0d: got %b want 1", d, ready_w[d]);
      end
      total++;
      if (valid_w[d] !== 1'b0) begin
        bad++; $display("FAIL reset_valid dut%0d: got %b want 0", d, valid_w[d]);
      end
      total++;
      if (rn_w[d] !== first_of(d)) begin
        bad++; $display("FAIL reset_round dut%0d: got %0d want %0d", d, rn_w[d], first_of(d));
      end
      total++;
      if (sout_w[d] !== '0) report_state("reset_state", d, sout_w[d], '0);
      start_v[d] = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (ready_w[d] !== 1'b1 || valid_w[d] !== 1'b0) begin
        bad++; $display("FAIL idle_after_reset dut%0d: ready=%b valid=%b want 1/0",
                        d, ready_w[d], valid_w[d]);
      end
    end
  endtask

  task automatic test_zero_state();
    do_start(0, '0);
    for (int k = 0; k < 24; k++) begin
      total++;
      if (rn_w[0] !== 5'(k) || ready_w[0] !== 1'b0 || valid_w[0] !== 1'b0) begin
        bad++; $display("FAIL seq24 step %0d: round=%0d ready=%b valid=%b want %0d/0/0",
                        k, rn_w[0], ready_w[0], valid_w[0], k);
      end
      @(negedge clk);
    end
    // Exactly 25 edges after the start was presented.
    total++;
    if (valid_w[0] !== 1'b1 || sout_w[0][63:0] !== 64'hF1258F7940E1DDE7) begin
      bad++; $display("FAIL zero_lane00: valid=%b lane00=%h want 1/f1258f7940e1dde7",
                      valid_w[0], sout_w[0][63:0]);
    end
    wait_result(0, "zero_full");
    total++;
    if (rn_w[0] !== 5'd0 || ready_w[0] !== 1'b1) begin
      bad++; $display("FAIL done_round24: round=%0d ready=%b want 0/1", rn_w[0], ready_w[0]);
    end
  endtask

  task automatic test_seq12();
    do_start(1, rand_state());
    for (int k = 0; k < 12; k++) begin
      total++;
      if (rn_w[1] !== 5'(12 + k) || valid_w[1] !== 1'b0) begin
        bad++; $display("FAIL seq12 step %0d: round=%0d valid=%b want %0d/0",
                        k, rn_w[1], valid_w[1], 12 + k);
      end
      @(negedge clk);
    end
    wait_result(1, "result12");
    total++;
    if (rn_w[1] !== 5'd12) begin
      bad++; $display("FAIL done_round12: got %0d want 12", rn_w[1]);
    end
  endtask

  task automatic test_start_ignored();
    do_start(0, rand_state());
    for (int k = 0; k < 24; k++) begin
      start_v[0] = 1'b1;
      st_v[0]    = rand_state();
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    wait_result(0, "start_ignored");
  endtask

  task automatic test_back_to_back();
    logic [1599:0] s2;
    s2 = rand_state();
    do_start(0, s2);
    total++;
    if (valid_w[0] !== 1'b0 || ready_w[0] !== 1'b0) begin
      bad++; $display("FAIL b2b_drop: valid=%b ready=%b want 0/0", valid_w[0], ready_w[0]);
    end
    total++;
    if (sout_w[0] !== s2) report_state("b2b_load", 0, sout_w[0], s2);
    wait_result(0, "b2b_result");
  endtask

  task automatic test_rst_mid();
    do_start(0, rand_state());
    repeat (10) @(negedge clk);
    total++;
    if (rn_w[0] !== 5'd10) begin
      bad++; $display("FAIL rst_mid_round: got %0d want 10", rn_w[0]);
    end
    void'(exp_q.pop_back());
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ready_w[0] !== 1'b1 || valid_w[0] !== 1'b0 || rn_w[0] !== 5'd0) begin
      bad++; $display("FAIL rst_mid_ctrl: ready=%b valid=%b round=%0d want 1/0/0",
                      ready_w[0], valid_w[0], rn_w[0]);
    end
    total++;
    if (sout_w[0] !== '0) report_state("rst_mid_state", 0, sout_w[0], '0);
    rst = 1'b0;
    @(negedge clk);
    do_start(0, rand_state());
    wait_result(0, "after_rst");
  endtask

  task automatic test_hold();
    for (int k = 0; k < 100; k++) begin
      st_v[0] = rand_state();
      @(negedge clk);
      total++;
      if (valid_w[0] !== 1'b1 || sout_w[0] !== last_exp) begin
        bad++; $display("FAIL hold cycle %0d: valid=%b lane00=%h want 1/%h",
                        k, valid_w[0], sout_w[0][63:0], last_exp[63:0]);
      end
    end
  endtask

  task automatic test_random(input int d, input int count);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 3)) begin
        st_v[d] = rand_state();
        @(negedge clk);
      end
      do_start(d, rand_state());
      wait_result(d, (d == 0) ? "random24" : "random12");
    end
  endtask

  initial begin
    init_rho();
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0;
      st_v[d]    = '0;
    end
    @(negedge clk);
    test_reset();
    test_zero_state();
    test_seq12();
    test_start_ignored();
    test_back_to_back();
    test_rst_mid();
    test_hold();
    test_random(0, 1000);
    test_random(1, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
